// File: rtl/my_and16.sv
// 16-bit bitwise AND. The combinational result is built from per-bit NAND cells;
// a registered copy carries a valid flag and a zero flag.

module my_nand1 (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = ~(i_a & i_b);

endmodule

module my_and16 #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_Q,
  output logic             OUT_VALID,
  output logic             ZERO_Q
);

  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_and;

  logic [WIDTH-1:0] r_outQ;
  logic             r_outValid;
  logic             r_zeroQ;

  // Each output bit is NOT(NAND(a,b)) so every bit stays fully independent.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    my_nand1 u_nand (
      .i_a (A[gi]),
      .i_b (B[gi]),
      .o_y (w_nand[gi])
    );
    assign w_and[gi] = ~w_nand[gi];
  end

  assign OUT = w_and;

  // Reset wins over capture; with no valid input the result holds but valid drops.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_outQ     <= '0;
      r_zeroQ    <= 1'b1;
      r_outValid <= 1'b0;
    end else if (IN_VALID) begin
      r_outQ     <= w_and;
      r_zeroQ    <= (w_and == '0);
      r_outValid <= 1'b1;
    end else begin
      r_outValid <= 1'b0;
    end
  end

  assign OUT_Q     = r_outQ;
  assign OUT_VALID = r_outValid;
  assign ZERO_Q    = r_zeroQ;

endmodule

// File: tb/tb_my_and16.sv
// Directed bench for my_and16: combinational patterns, registered capture,
// hold, zero flag, back-to-back flow and reset priority.

module tb_my_and16;

  logic        CLK;
  logic        RST_N;
  logic [15:0] A;
  logic [15:0] B;
  logic        IN_VALID;
  logic [15:0] OUT;
  logic [15:0] OUT_Q;
  logic        OUT_VALID;
  logic        ZERO_Q;

  int checks = 0;
  int errors = 0;

  my_and16 #(.WIDTH(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .A         (A),
    .B         (B),
    .IN_VALID  (IN_VALID),
    .OUT       (OUT),
    .OUT_Q     (OUT_Q),
    .OUT_VALID (OUT_VALID),
    .ZERO_Q    (ZERO_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic rstN, input logic valid,
                               input logic [15:0] a, input logic [15:0] b);
    RST_N    = rstN;
    IN_VALID = valid;
    A        = a;
    B        = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic checkReg(input string tag, input logic [15:0] q,
                          input logic z, input logic v);
    checkOutput({tag, "_outq"}, OUT_Q, q);
    checkOutput({tag, "_zero"}, {15'd0, ZERO_Q}, {15'd0, z});
    checkOutput({tag, "_valid"}, {15'd0, OUT_VALID}, {15'd0, v});
  endtask

  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    // Reset state, with valid high to show reset ignores it
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0F0F);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0F0F);
    checkReg("reset", 16'h0000, 1'b1, 1'b0);
    checkOutput("reset_comb", OUT, 16'h0F0F);

    // Combinational patterns while still in reset
    A = 16'h0000; B = 16'hFFFF; #1; checkOutput("comb_0000_ffff", OUT, 16'h0000);
    A = 16'hFFFF; B = 16'hFFFF; #1; checkOutput("comb_ffff_ffff", OUT, 16'hFFFF);
    A = 16'hAAAA; B = 16'h5555; #1; checkOutput("comb_aaaa_5555", OUT, 16'h0000);
    A = 16'h1234; B = 16'hFF0F; #1; checkOutput("comb_1234_ff0f", OUT, 16'h1204);
    A = 16'hFF0F; B = 16'h1234; #1; checkOutput("comb_commute", OUT, 16'h1204);
    A = 16'hC3A5; B = 16'hC3A5; #1; checkOutput("comb_self", OUT, 16'hC3A5);
    A = 16'h0001; B = 16'h0001; #1; checkOutput("comb_bit0", OUT, 16'h0001);
    A = 16'h8000; B = 16'h8001; #1; checkOutput("comb_bit15", OUT, 16'h8000);
    checkReg("reset_hold", 16'h0000, 1'b1, 1'b0);

    // First capture right after reset release, then hold
    applyStimulus(1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    checkReg("cap_f0f0", 16'hF000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    checkReg("hold", 16'hF000, 1'b0, 1'b0);
    checkOutput("hold_comb", OUT, 16'hFFFF);

    // Zero flag
    applyStimulus(1'b1, 1'b1, 16'h00FF, 16'hFF00);
    checkReg("zero", 16'h0000, 1'b1, 1'b1);

    // Back-to-back captures
    applyStimulus(1'b1, 1'b1, 16'h0001, 16'h0001);
    checkReg("b2b_1", 16'h0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0003, 16'h0002);
    checkReg("b2b_2", 16'h0002, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h000F, 16'h000F);
    checkReg("b2b_3", 16'h000F, 1'b0, 1'b1);

    // Reset asserted on the same edge as a valid capture
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
    checkReg("rst_mid", 16'h0000, 1'b1, 1'b0);
    checkOutput("rst_mid_comb", OUT, 16'hFFFF);

    // Capture after release, both operand orders, identity operands
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'hFF0F);
    checkReg("cap_1204", 16'h1204, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hFF0F, 16'h1234);
    checkReg("cap_commute", 16'h1204, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h5A3C, 16'hFFFF);
    checkReg("cap_ident", 16'h5A3C, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h5A3C, 16'h0000);
    checkReg("cap_zero_op", 16'h0000, 1'b1, 1'b1);

    // Walking single bits across both operands
    for (int i = 0; i < 16; i++) begin
      A = 16'h0001 << i; B = 16'hFFFF; #1;
      checkOutput("walk_a", OUT, 16'h0001 << i);
      A = 16'hFFFF; B = ~(16'h0001 << i); #1;
      checkOutput("walk_b", OUT, ~(16'h0001 << i));
    end

    // Random combinational sweep against the bitwise model
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      A = ra; B = rb; #1;
      checkOutput("sweep", OUT, ra & rb);
    end

    // A few random registered captures
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(1'b1, 1'b1, ra, rb);
      checkReg("rand_cap", ra & rb, (ra & rb) == 16'h0000, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_and16.md
MY_AND16 -- requirements
Module: my_and16

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result bit width; only 16 is required to be supported and verified.
REQ-002 Port: CLK  input  1  rising-edge clock for the registered stage.
REQ-003 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-004 Port: A  input  16  operand A.
REQ-005 Port: B  input  16  operand B.
REQ-006 Port: IN_VALID  input  1  qualifies A/B for capture into the registered stage.
REQ-007 Port: OUT  output  16  combinational bitwise AND of A and B.
REQ-008 Port: OUT_Q  output  16  registered bitwise AND result.
REQ-009 Port: OUT_VALID  output  1  high when OUT_Q holds a result captured on the previous edge.
REQ-010 Port: ZERO_Q  output  1  registered flag, high when the captured result is all zeros.
REQ-011 Reset is synchronous, active-low; single clock domain (CLK) for all state.

Function
REQ-012 OUT[i] SHALL equal A[i] AND B[i] for every i in 0..15, purely combinational, zero cycles latency, no dependence on CLK, RST_N or IN_VALID.
REQ-013 OUT SHALL settle within one delta/propagation of any A or B change; no latches, no X on OUT for known inputs.
REQ-014 Each bit SHALL be built structurally as NOT(NAND(a,b)) from a one-bit NAND cell, replicated 16 times via a generate loop; behavioural "&" on the vector is not used for OUT.
REQ-015 On a rising CLK edge with RST_N=1 and IN_VALID=1: OUT_Q <= A & B, ZERO_Q <= (A & B == 0), OUT_VALID <= 1.
REQ-016 On a rising CLK edge with RST_N=1 and IN_VALID=0: OUT_Q and ZERO_Q hold, OUT_VALID <= 0.
REQ-017 Registered latency SHALL be exactly one cycle from IN_VALID sample to OUT_VALID/OUT_Q.
REQ-018 Back-to-back IN_VALID SHALL produce back-to-back OUT_VALID with one result per cycle; no stall, no backpressure.
REQ-019 Identity boundaries: A & 16'hFFFF = A; A & 16'h0000 = 0; A & A = A; result is commutative (A&B = B&A) on both OUT and OUT_Q.
REQ-020 No arithmetic, no carries; bits are fully independent (changing A[i] or B[i] affects only bit i of OUT/OUT_Q).

Reset
REQ-021 On a rising CLK edge with RST_N=0: OUT_Q <= 16'h0000, ZERO_Q <= 1, OUT_VALID <= 0, regardless of IN_VALID.
REQ-022 Reset has priority over capture; reset asserted mid-stream discards the in-flight capture that edge.
REQ-023 OUT (combinational) SHALL be unaffected by reset and remain A & B during reset.
REQ-024 After RST_N deasserts, the first edge with IN_VALID=1 captures normally (no extra warm-up cycle).

Verification
REQ-025 Combinational patterns, no clock needed: A=0000,B=FFFF -> OUT=0000; A=FFFF,B=FFFF -> OUT=FFFF; A=AAAA,B=5555 -> OUT=0000; A=1234,B=FF0F -> OUT=1204.
REQ-026 Sweep: A over all 65536 values with B stepped through all values (or >=1e6 random B per A band), 50-time-unit step, OUT checked against the A & B model each step; zero mismatches.
REQ-027 Registered path: IN_VALID=1 with A=F0F0,B=FF00 at edge n -> OUT_Q=F000, ZERO_Q=0, OUT_VALID=1 at edge n+1; then IN_VALID=0 -> OUT_VALID=0, OUT_Q holds F000.
REQ-028 Zero flag: IN_VALID=1, A=00FF,B=FF00 -> OUT_Q=0000, ZERO_Q=1, OUT_VALID=1 one cycle later.
REQ-029 Reset mid-stream: RST_N=0 on the same edge as IN_VALID=1, A=FFFF,B=FFFF -> OUT_Q=0000, ZERO_Q=1, OUT_VALID=0; OUT still FFFF combinationally.
REQ-030 Back-to-back: IN_VALID=1 for 3 cycles with (1,1),(3,2),(F,F) -> OUT_Q sequence 0001,0002,000F with OUT_VALID high 3 consecutive cycles.
